// File: rtl/int_alu_exec_pkg.sv
// Shared types for the integer ALU execution pipe.
// Holds datapath widths, operand-select and ALU opcode encodings, and the
// packed payloads carried by the S1 (operand) and S2 (result) registers.
package int_alu_exec_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ROB_IDX = 4;
    localparam int unsigned PRF_IDX = 6;
    localparam int unsigned ARF_IDX = 5;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_t;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_ZERO = 2'd2
    } op2_sel_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // S1 payload: uop tags plus already-selected operands.
    // The opcode is kept as raw bits so undefined encodings survive to the ALU.
    typedef struct packed {
        logic [ROB_IDX-1:0] rob_id;
        logic [PRF_IDX-1:0] rd_phy;
        logic [ARF_IDX-1:0] rd_arch;
        logic [3:0]         alu_op;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
    } fu_alu_reg_t;

    // S2 payload: what gets broadcast on the CDB slot.
    typedef struct packed {
        logic [ROB_IDX-1:0] rob_id;
        logic [PRF_IDX-1:0] rd_phy;
        logic [ARF_IDX-1:0] rd_arch;
        logic [XLEN-1:0]    value;
    } cdb_res_t;

endpackage

// File: rtl/int_alu_exec_if.sv
// Issue and CDB signal bundle between the reservation station / CDB arbiter
// (master) and the ALU execution pipe (slave).
//   in_*      : issued uop with PRF read data, in_ready back-pressure
//   cdb_*     : held result broadcast, cdb_grant from the arbiter
interface int_alu_exec_if;
    import int_alu_exec_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [ROB_IDX-1:0] in_rob_id;
    logic [PRF_IDX-1:0] in_rd_phy;
    logic [ARF_IDX-1:0] in_rd_arch;
    logic [1:0]         in_op1_sel;
    logic [1:0]         in_op2_sel;
    logic [3:0]         in_fu_opcode;
    logic [XLEN-1:0]    in_imm;
    logic [XLEN-1:0]    in_pc;
    logic [XLEN-1:0]    in_rs1_value;
    logic [XLEN-1:0]    in_rs2_value;

    logic               cdb_valid;
    logic               cdb_grant;
    logic [ROB_IDX-1:0] cdb_rob_id;
    logic [PRF_IDX-1:0] cdb_rd_phy;
    logic [ARF_IDX-1:0] cdb_rd_arch;
    logic [XLEN-1:0]    cdb_rd_value;

    modport master (
        output in_valid, in_rob_id, in_rd_phy, in_rd_arch, in_op1_sel,
               in_op2_sel, in_fu_opcode, in_imm, in_pc, in_rs1_value,
               in_rs2_value, cdb_grant,
        input  in_ready, cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch,
               cdb_rd_value
    );

    modport slave (
        input  in_valid, in_rob_id, in_rd_phy, in_rd_arch, in_op1_sel,
               in_op2_sel, in_fu_opcode, in_imm, in_pc, in_rs1_value,
               in_rs2_value, cdb_grant,
        output in_ready, cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch,
               cdb_rd_value
    );

endinterface

// File: rtl/int_alu_exec_alu_core.sv
// Combinational integer ALU: (op1, op2, opcode) -> result.
//   i_op1, i_op2 : operands
//   i_alu_op     : opcode bits; encodings outside the defined set yield 0
//   o_result_c   : combinational result
module int_alu_exec_alu_core
    import int_alu_exec_pkg::*;
(
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [3:0]      i_alu_op,
    output logic [XLEN-1:0] o_result_c
);

    logic [4:0] w_shamt;

    assign w_shamt = i_op2[4:0];

    always_comb begin
        o_result_c = '0;
        case (i_alu_op)
            ALU_ADD:  o_result_c = i_op1 + i_op2;
            ALU_SUB:  o_result_c = i_op1 - i_op2;
            ALU_SLL:  o_result_c = i_op1 << w_shamt;
            ALU_SLT:  o_result_c = XLEN'($signed(i_op1) < $signed(i_op2));
            ALU_SLTU: o_result_c = XLEN'(i_op1 < i_op2);
            ALU_XOR:  o_result_c = i_op1 ^ i_op2;
            ALU_SRL:  o_result_c = i_op1 >> w_shamt;
            ALU_SRA:  o_result_c = XLEN'($signed(i_op1) >>> w_shamt);
            ALU_OR:   o_result_c = i_op1 | i_op2;
            ALU_AND:  o_result_c = i_op1 & i_op2;
            default:  o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/int_alu_exec.sv
// Two-stage integer ALU execution pipe between the reservation station and
// a CDB slot. S1 registers the uop with selected operands, S2 registers the
// ALU result and holds it on the CDB until granted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : issue handshake in, CDB broadcast out (slave side)
module int_alu_exec
    import int_alu_exec_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    int_alu_exec_if.slave  bus
);

    fu_alu_reg_t     r_s1;
    logic            r_s1_valid;
    cdb_res_t        r_s2;
    logic            r_s2_valid;

    fu_alu_reg_t     w_s1_next;
    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_accept;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_s2_value;

    // Stage advance chain: a stage may move when it is empty or its consumer moves.
    assign w_s2_adv = !r_s2_valid || bus.cdb_grant;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = bus.in_valid && w_s1_adv;

    assign bus.in_ready     = w_s1_adv;
    assign bus.cdb_valid    = r_s2_valid;
    assign bus.cdb_rob_id   = r_s2.rob_id;
    assign bus.cdb_rd_phy   = r_s2.rd_phy;
    assign bus.cdb_rd_arch  = r_s2.rd_arch;
    assign bus.cdb_rd_value = r_s2.value;

    // Operand selection for the incoming uop.
    always_comb begin
        w_s1_next         = '0;
        w_s1_next.rob_id  = bus.in_rob_id;
        w_s1_next.rd_phy  = bus.in_rd_phy;
        w_s1_next.rd_arch = bus.in_rd_arch;
        w_s1_next.alu_op  = bus.in_fu_opcode;
        case (bus.in_op1_sel)
            OP1_RS1: w_s1_next.op1 = bus.in_rs1_value;
            OP1_PC:  w_s1_next.op1 = bus.in_pc;
            default: w_s1_next.op1 = '0;
        endcase
        case (bus.in_op2_sel)
            OP2_RS2: w_s1_next.op2 = bus.in_rs2_value;
            OP2_IMM: w_s1_next.op2 = bus.in_imm;
            default: w_s1_next.op2 = '0;
        endcase
    end

    int_alu_exec_alu_core u_alu_core (
        .i_op1      (r_s1.op1),
        .i_op2      (r_s1.op2),
        .i_alu_op   (r_s1.alu_op),
        .o_result_c (w_alu_result)
    );

    // x0 writes still complete through the CDB so the ROB retires them.
    assign w_s2_value = (r_s1.rd_arch == '0) ? '0 : w_alu_result;

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
            r_s2       <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1 <= w_s1_next;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2.rob_id  <= r_s1.rob_id;
                    r_s2.rd_phy  <= r_s1.rd_phy;
                    r_s2.rd_arch <= r_s1.rd_arch;
                    r_s2.value   <= w_s2_value;
                end
            end
        end
    end

endmodule
